fetch_ctrl: RTL and testbench

//  Sequences the fetch-stage PC against a variable-latency instruction memory (req/ready, rvalid).

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_ctrl_if.sv | 28 ++
 rtl/fetch_ctrl_adder.sv | 12 +
 rtl/fetch_ctrl.sv | 97 +++++++++
 tb/tb_fetch_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_WAIT
  } fetch_state_t;

  localparam logic [63:0] PC_STEP = 64'd4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory port between the fetch controller (master) and imem (slave).
interface fetch_ctrl_if #(
  parameter int INSTR_W = 32
);

  logic               imem_req;
  logic [63:0]        imem_addr_F;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr_F,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr_F,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_ctrl_adder.sv
// Plain W-bit wrap-around adder shared by the PC datapath.
module fetch_ctrl_adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = a + b;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer: one outstanding imem request, branch redirects with
// wrong-path response dropping, and a single-entry decode-facing output register.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCSrc_F,
  input  logic [63:0]        PCBranch_F,
  input  logic               stall_D,
  fetch_ctrl_if.master       imem,
  output logic               instr_valid_D,
  output logic [INSTR_W-1:0] instr_D,
  output logic [63:0]        pc_D
);

  fetch_state_t state;
  logic [63:0]  pc;
  logic [63:0]  req_pc;
  logic [63:0]  next_seq_pc;
  logic         drop;
  logic         slot_ok;

  fetch_ctrl_adder #(.W(64)) u_pc_adder (
    .a (req_pc),
    .b (PC_STEP),
    .y (next_seq_pc)
  );

  // Only issue when the output register will be free by the time the response lands.
  assign slot_ok          = ~instr_valid_D | ~stall_D;
  assign imem.imem_addr_F = pc;
  assign imem.imem_req    = (state == FS_REQ) & slot_ok & ~PCSrc_F;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FS_IDLE;
      pc            <= RESET_PC;
      req_pc        <= 64'd0;
      drop          <= 1'b0;
      instr_valid_D <= 1'b0;
      instr_D       <= '0;
      pc_D          <= 64'd0;
    end else begin
      if (instr_valid_D & ~stall_D)
        instr_valid_D <= 1'b0;

      case (state)
        FS_IDLE: begin
          state <= FS_REQ;
        end

        FS_REQ: begin
          if (PCSrc_F) begin
            pc            <= PCBranch_F;
            instr_valid_D <= 1'b0;
          end else if (imem.imem_req & imem.imem_ready) begin
            req_pc <= pc;
            state  <= FS_WAIT;
          end
        end

        FS_WAIT: begin
          // A redirect kills whatever is in flight; if it has not returned yet, drop it later.
          if (PCSrc_F) begin
            pc            <= PCBranch_F;
            instr_valid_D <= 1'b0;
            if (imem.imem_rvalid) begin
              drop  <= 1'b0;
              state <= FS_REQ;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem.imem_rvalid) begin
            if (drop) begin
              drop <= 1'b0;
            end else begin
              instr_D       <= imem.imem_rdata;
              pc_D          <= req_pc;
              instr_valid_D <= 1'b1;
              pc            <= next_seq_pc;
            end
            state <= FS_REQ;
          end
        end

        default: begin
          state <= FS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: a RESET_PC=0 instance for the main
// sequencing/redirect/stall cases and a wrap-around RESET_PC instance for reset behaviour.
module tb_fetch_ctrl;

  logic clk;
  logic reset;
  logic reset1;

  logic        pcsrc;
  logic [63:0] pcbranch;
  logic        stall;
  logic        pcsrc1;
  logic [63:0] pcbranch1;
  logic        stall1;

  logic        valid0;
  logic [31:0] instr0;
  logic [63:0] pcd0;
  logic        valid1;
  logic [31:0] instr1;
  logic [63:0] pcd1;

  int total_count;
  int pass_count;
  int fail_count;
  int accepts;
  int acc_before;

  fetch_ctrl_if #(.INSTR_W(32)) bus0 ();
  fetch_ctrl_if #(.INSTR_W(32)) bus1 ();

  fetch_ctrl #(.RESET_PC(64'h0), .INSTR_W(32)) dut0 (
    .clk           (clk),
    .reset         (reset),
    .PCSrc_F       (pcsrc),
    .PCBranch_F    (pcbranch),
    .stall_D       (stall),
    .imem          (bus0.master),
    .instr_valid_D (valid0),
    .instr_D       (instr0),
    .pc_D          (pcd0)
  );

  fetch_ctrl #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .INSTR_W(32)) dut1 (
    .clk           (clk),
    .reset         (reset1),
    .PCSrc_F       (pcsrc1),
    .PCBranch_F    (pcbranch1),
    .stall_D       (stall1),
    .imem          (bus1.master),
    .instr_valid_D (valid1),
    .instr_D       (instr1),
    .pc_D          (pcd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus0.imem_req && bus0.imem_ready)
      accepts <= accepts + 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic src, input logic [63:0] tgt, input logic stl,
                               input logic rdy, input logic rv, input logic [31:0] rd);
    pcsrc            = src;
    pcbranch         = tgt;
    stall            = stl;
    bus0.imem_ready  = rdy;
    bus0.imem_rvalid = rv;
    bus0.imem_rdata  = rd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_count++;
    assert (obs === exp)
      pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total_count = 0;
    pass_count  = 0;
    fail_count  = 0;
    accepts     = 0;
    reset  = 1'b1;
    reset1 = 1'b1;
    pcsrc1 = 1'b0; pcbranch1 = 64'd0; stall1 = 1'b0;
    bus1.imem_ready = 1'b0; bus1.imem_rvalid = 1'b0; bus1.imem_rdata = 32'd0;
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    #2;
    checkOutput("rst_addr",   bus0.imem_addr_F, 64'd0);
    checkOutput("rst_valid",  {63'd0, valid0},  64'd0);
    checkOutput("rst_instr",  {32'd0, instr0},  64'd0);
    checkOutput("rst_pcd",    pcd0,             64'd0);
    checkOutput("rst_req",    {63'd0, bus0.imem_req}, 64'd0);

    // Test 1: first fetch after reset
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("idle_req",   {63'd0, bus0.imem_req}, 64'd0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("t1_req",     {63'd0, bus0.imem_req}, 64'd1);
    checkOutput("t1_addr",    bus0.imem_addr_F, 64'd0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 32'hA0);
    checkOutput("t1_wait_req", {63'd0, bus0.imem_req}, 64'd0);
    tick();
    // Test 2: decode stalls with the slot full
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("t1_instr",   {32'd0, instr0}, 64'hA0);
    checkOutput("t1_pcd",     pcd0,            64'd0);
    checkOutput("t1_valid",   {63'd0, valid0}, 64'd1);
    checkOutput("t1_next",    bus0.imem_addr_F, 64'd4);
    checkOutput("t2_req_stall", {63'd0, bus0.imem_req}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("t2_req_held",   {63'd0, bus0.imem_req}, 64'd0);
      checkOutput("t2_instr_held", {32'd0, instr0}, 64'hA0);
      checkOutput("t2_pcd_held",   pcd0, 64'd0);
    end
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("t2_release_req",  {63'd0, bus0.imem_req}, 64'd1);
    checkOutput("t2_release_addr", bus0.imem_addr_F, 64'd4);

    // Test 3: redirect while waiting, late wrong-path response
    tick();
    applyStimulus(1'b1, 64'h100, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("t3_consumed", {63'd0, valid0}, 64'd0);
    checkOutput("t3_req",      {63'd0, bus0.imem_req}, 64'd0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("t3_addr",     bus0.imem_addr_F, 64'h100);
    checkOutput("t3_wait_req", {63'd0, bus0.imem_req}, 64'd0);
    tick();
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 32'hDEAD);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("t3_dropped",  {63'd0, valid0}, 64'd0);
    checkOutput("t3_next",     bus0.imem_addr_F, 64'h100);
    checkOutput("t3_req_next", {63'd0, bus0.imem_req}, 64'd1);

    // Test 4: redirect coincides with the response
    tick();
    applyStimulus(1'b1, 64'h200, 1'b0, 1'b1, 1'b1, 32'hBEEF);
    checkOutput("t4_req",   {63'd0, bus0.imem_req}, 64'd0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("t4_valid", {63'd0, valid0}, 64'd0);
    checkOutput("t4_addr",  bus0.imem_addr_F, 64'h200);
    checkOutput("t4_req_next", {63'd0, bus0.imem_req}, 64'd1);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 32'hC0);
    tick();
    // Test 5: memory back-pressure
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    acc_before = accepts;
    checkOutput("t4_nodrop_instr", {32'd0, instr0}, 64'hC0);
    checkOutput("t4_nodrop_pcd",   pcd0, 64'h200);
    checkOutput("t4_nodrop_valid", {63'd0, valid0}, 64'd1);
    checkOutput("t5_req",  {63'd0, bus0.imem_req}, 64'd1);
    checkOutput("t5_addr", bus0.imem_addr_F, 64'h204);
    for (int i = 0; i < 3; i++) begin
      tick();
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("t5_req_held",  {63'd0, bus0.imem_req}, 64'd1);
      checkOutput("t5_addr_held", bus0.imem_addr_F, 64'h204);
    end
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("t5_req_ready", {63'd0, bus0.imem_req}, 64'd1);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("t5_wait_req", {63'd0, bus0.imem_req}, 64'd0);
    checkOutput("t5_accepts",  64'(accepts - acc_before), 64'd1);
    checkOutput("t5_valid",    {63'd0, valid0}, 64'd0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 32'hE0);
    tick();
    // rvalid outside WAIT must be ignored
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 32'hBAD);
    checkOutput("t5_instr", {32'd0, instr0}, 64'hE0);
    checkOutput("t5_pcd",   pcd0, 64'h204);
    checkOutput("t5_next",  bus0.imem_addr_F, 64'h208);
    tick();
    // Redirect while in REQ with a valid instruction held
    applyStimulus(1'b1, 64'h303, 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("proto_instr", {32'd0, instr0}, 64'hE0);
    checkOutput("proto_valid", {63'd0, valid0}, 64'd1);
    checkOutput("req_redir_req", {63'd0, bus0.imem_req}, 64'd0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("req_redir_addr",  bus0.imem_addr_F, 64'h303);
    checkOutput("req_redir_flush", {63'd0, valid0}, 64'd0);
    checkOutput("req_redir_req2",  {63'd0, bus0.imem_req}, 64'd1);

    // Test 6: wrap-around reset PC and reset during WAIT
    checkOutput("t6_rst_addr", bus1.imem_addr_F, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    reset1 = 1'b0;
    bus1.imem_ready = 1'b1;
    #1;
    checkOutput("t6_idle_req", {63'd0, bus1.imem_req}, 64'd0);
    tick();
    checkOutput("t6_req",  {63'd0, bus1.imem_req}, 64'd1);
    checkOutput("t6_addr", bus1.imem_addr_F, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    bus1.imem_rvalid = 1'b1;
    bus1.imem_rdata  = 32'hF0;
    tick();
    bus1.imem_rvalid = 1'b0;
    #1;
    checkOutput("t6_pcd",   pcd1, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("t6_instr", {32'd0, instr1}, 64'hF0);
    checkOutput("t6_wrap",  bus1.imem_addr_F, 64'd0);
    tick();
    checkOutput("t6_wait", {63'd0, bus1.imem_req}, 64'd0);
    reset1 = 1'b1;
    #1;
    checkOutput("t6_rst_valid", {63'd0, valid1}, 64'd0);
    checkOutput("t6_rst_instr", {32'd0, instr1}, 64'd0);
    checkOutput("t6_rst_pcd",   pcd1, 64'd0);
    checkOutput("t6_rst_pc",    bus1.imem_addr_F, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    reset1 = 1'b0;
    bus1.imem_rvalid = 1'b1;
    bus1.imem_rdata  = 32'h77;
    tick();
    bus1.imem_rvalid = 1'b0;
    #1;
    checkOutput("t6_late_valid", {63'd0, valid1}, 64'd0);
    checkOutput("t6_late_instr", {32'd0, instr1}, 64'd0);
    checkOutput("t6_late_req",   {63'd0, bus1.imem_req}, 64'd1);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
